// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan controller bus: enable/row inputs from the board, column drive
// and accepted-key reporting toward the game logic.
// Signals:
//   enable    scanning enabled (into controller)
//   row       active-low keypad rows (into controller, asynchronous)
//   col       active-low column drive (from controller)
//   key_valid one-cycle accepted-press pulse (from controller)
//   key_code  accepted key, row*3+col (from controller)
//   key_held  accepted key still pressed (from controller)
interface keypad_scan_ctrl_if;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned CODE_W = 4;

  logic              enable;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_held;

  // Controller side
  modport master (
    input  enable,
    input  row,
    output col,
    output key_valid,
    output key_code,
    output key_held
  );

  // Board / game-logic side
  modport slave (
    output enable,
    output row,
    input  col,
    input  key_valid,
    input  key_code,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Scan controller for the 3x3 keypad. Drives one active-low column per dwell
// of SCAN_DIV cycles, samples the synchronised rows once per dwell, and accepts
// a press (or release) after DEBOUNCE_N consecutive matching samples.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    keypad_scan_ctrl_if.master (enable, row, col, key_valid,
//          key_code, key_held)
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 10
) (
  input logic                clk,
  input logic                reset,
  keypad_scan_ctrl_if.master bus
);

  localparam int unsigned DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW   = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned KW   = 4;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DEBOUNCE = 2'd2,
    HELD     = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dwell, dwell_nx;
  logic [IW-1:0] col_idx, col_idx_nx;
  logic [IW-1:0] cand, cand_nx;
  // Shared counter: consecutive low samples in DEBOUNCE, high samples in HELD
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    row_s1, row_s2;

  logic [2:0]    col_nx;
  logic          valid_nx;
  logic [KW-1:0] code_nx;
  logic          held_nx;

  logic          sample;
  logic          any_low;
  logic [IW-1:0] first_low;
  logic          cand_low;
  logic [IW-1:0] col_adv;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic [IW-1:0] accept_row;

  // Two-flop row synchroniser, idles at "no key"
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1 <= 3'b111;
      row_s2 <= 3'b111;
    end else begin
      row_s1 <= bus.row;
      row_s2 <= row_s1;
    end
  end

  // Sample decode and helpers
  always_comb begin
    sample  = (state != IDLE) && (dwell == DWELL_LAST);
    any_low = (row_s2 != 3'b111);
    if (!row_s2[0])      first_low = 2'd0;
    else if (!row_s2[1]) first_low = 2'd1;
    else                 first_low = 2'd2;
    unique case (cand)
      2'd0:    cand_low = ~row_s2[0];
      2'd1:    cand_low = ~row_s2[1];
      default: cand_low = ~row_s2[2];
    endcase
    col_adv = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    cnt_inc = cnt + CW'(1);
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      dwell         <= '0;
      col_idx       <= '0;
      cand          <= '0;
      cnt           <= '0;
      bus.col       <= 3'b111;
      bus.key_valid <= 1'b0;
      bus.key_code  <= '0;
      bus.key_held  <= 1'b0;
    end else begin
      state         <= state_nx;
      dwell         <= dwell_nx;
      col_idx       <= col_idx_nx;
      cand          <= cand_nx;
      cnt           <= cnt_nx;
      bus.col       <= col_nx;
      bus.key_valid <= valid_nx;
      bus.key_code  <= code_nx;
      bus.key_held  <= held_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    dwell_nx   = dwell;
    col_idx_nx = col_idx;
    cand_nx    = cand;
    cnt_nx     = cnt;
    valid_nx   = 1'b0;
    code_nx    = bus.key_code;
    held_nx    = bus.key_held;
    accept     = 1'b0;
    accept_row = cand;

    if (!bus.enable) begin
      state_nx   = IDLE;
      dwell_nx   = '0;
      col_idx_nx = '0;
      cnt_nx     = '0;
      held_nx    = 1'b0;
    end else begin
      if (state != IDLE) begin
        dwell_nx = sample ? '0 : dwell + DW'(1);
      end
      unique case (state)
        IDLE: begin
          state_nx   = SCAN;
          dwell_nx   = '0;
          col_idx_nx = '0;
          cnt_nx     = '0;
        end
        SCAN: begin
          if (sample) begin
            if (any_low) begin
              cand_nx    = first_low;
              accept_row = first_low;
              if (CNT_TARGET == CW'(1)) begin
                accept = 1'b1;
              end else begin
                state_nx = DEBOUNCE;
                cnt_nx   = CW'(1);
              end
            end else begin
              col_idx_nx = col_adv;
            end
          end
        end
        DEBOUNCE: begin
          if (sample) begin
            if (cand_low) begin
              if (cnt_inc == CNT_TARGET) accept = 1'b1;
              else                       cnt_nx = cnt_inc;
            end else begin
              state_nx   = SCAN;
              col_idx_nx = col_adv;
              cnt_nx     = '0;
            end
          end
        end
        HELD: begin
          if (sample) begin
            if (!cand_low) begin
              if (cnt_inc == CNT_TARGET) begin
                held_nx    = 1'b0;
                state_nx   = SCAN;
                col_idx_nx = col_adv;
                cnt_nx     = '0;
              end else begin
                cnt_nx = cnt_inc;
              end
            end else begin
              cnt_nx = '0;
            end
          end
        end
        default: state_nx = IDLE;
      endcase

      // Accepted press: report once, then watch the same key for release
      if (accept) begin
        state_nx = HELD;
        cnt_nx   = '0;
        valid_nx = 1'b1;
        held_nx  = 1'b1;
        code_nx  = KW'(accept_row) * KW'(3) + KW'(col_idx);
      end
    end

    col_nx = (state_nx == IDLE) ? 3'b111 : ~(3'b001 << col_idx_nx);
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: keypad model closes row r when key (r,c) is
// pressed and column c is driven. A behavioural reference model is compared
// against the DEBOUNCE_N=3 instance every cycle; a DEBOUNCE_N=1 instance gets
// hand-computed latency checks.
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DN = 3;

  logic clk = 1'b0;
  logic reset;
  logic [8:0] keys0 = '0;
  logic [8:0] keys1 = '0;
  int checks = 0;
  int failures = 0;
  logic cmp_on = 1'b0;

  keypad_scan_ctrl_if bus0 ();
  keypad_scan_ctrl_if bus1 ();

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_N(DN)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_N(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Keypad: key bit r*3+c pulls row r low while column c is driven low
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      bus0.row[r] = ~|(keys0[r*3 +: 3] & ~bus0.col);
      bus1.row[r] = ~|(keys1[r*3 +: 3] & ~bus1.col);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sample once per dwell on the row value seen two edges ago
  logic [2:0] h1, h2;
  logic       m_scan, m_valid, m_held;
  int         m_t, m_c, m_lock, m_row, m_run;
  logic [3:0] m_code;
  logic [2:0] m_col;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1 <= 3'b111; h2 <= 3'b111;
      m_scan <= 1'b0; m_t <= 0; m_c <= 0; m_lock <= 0; m_row <= 0; m_run <= 0;
      m_valid <= 1'b0; m_held <= 1'b0; m_code <= '0; m_col <= 3'b111;
    end else begin : step
      automatic logic [2:0] v = h2;
      automatic int c = m_c;
      automatic int lock = m_lock;
      automatic int run = m_run;
      automatic int rw = m_row;
      automatic int t = m_t;
      automatic logic scan = m_scan;
      automatic logic held = m_held;
      automatic logic acc = 1'b0;
      automatic logic [3:0] code = m_code;
      if (!bus0.enable) begin
        scan = 0; held = 0; lock = 0; run = 0; t = 0; c = 0;
      end else if (!scan) begin
        scan = 1; c = 0; t = 0; lock = 0; run = 0;
      end else begin
        if (t % SD == SD - 1) begin
          if (lock == 0) begin
            if (v != 3'b111) begin
              rw = !v[0] ? 0 : (!v[1] ? 1 : 2);
              if (DN == 1) acc = 1;
              else begin lock = 1; run = 1; end
            end else c = (c + 1) % 3;
          end else if (lock == 1) begin
            if (!v[rw]) begin run++; if (run == DN) acc = 1; end
            else begin lock = 0; run = 0; c = (c + 1) % 3; end
          end else begin
            if (v[rw]) begin
              run++;
              if (run == DN) begin held = 0; lock = 0; run = 0; c = (c + 1) % 3; end
            end else run = 0;
          end
        end
        t++;
      end
      if (acc) begin
        code = 4'(rw * 3 + c); held = 1; lock = 2; run = 0;
      end
      h2 <= h1; h1 <= bus0.row;
      m_scan <= scan; m_t <= t; m_c <= c; m_lock <= lock; m_row <= rw; m_run <= run;
      m_valid <= acc; m_held <= held; m_code <= code;
      m_col <= scan ? ~(3'b001 << c) : 3'b111;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_col", 32'(bus0.col), 32'(m_col));
      chk("model_key_valid", 32'(bus0.key_valid), 32'(m_valid));
      chk("model_key_code", 32'(bus0.key_code), 32'(m_code));
      chk("model_key_held", 32'(bus0.key_held), 32'(m_held));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pulses, bad, cap;
    logic [2:0] rot [0:2];
    logic got;
    rot[0] = 3'b110; rot[1] = 3'b101; rot[2] = 3'b011;
    reset = 1'b0;
    bus0.enable = 1'b0;
    bus1.enable = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_col", 32'(bus0.col), 32'h7);
    chk("rst_valid", 32'(bus0.key_valid), 0);
    chk("rst_code", 32'(bus0.key_code), 0);
    chk("rst_held", 32'(bus0.key_held), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus0.col !== 3'b111 || bus0.key_valid !== 1'b0 || bus0.key_held !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);
    chk("idle_code", 32'(bus0.key_code), 0);

    // Rotation with no keys
    bus0.enable = 1'b1;
    bad = 0; pulses = 0;
    for (int kk = 1; kk <= 24; kk++) begin
      @(negedge clk);
      if (bus0.col !== rot[((kk - 1) / SD) % 3]) bad++;
      if (bus0.key_valid) pulses++;
    end
    chk("rotation_col", 32'(bad), 0);
    chk("rotation_no_valid", 32'(pulses), 0);

    // Clean press of key (2,1)
    bus0.enable = 1'b0;
    @(negedge clk);
    keys0 = 9'b1 << 7;
    bus0.enable = 1'b1;
    pulses = 0; bad = 0; cap = -1; k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus0.key_valid) begin
        pulses++;
        if (cap < 0) begin cap = i; chk("press_code", 32'(bus0.key_code), 7); end
      end
      if (cap > 0 && i > cap && (bus0.col !== 3'b101 || bus0.key_held !== 1'b1)) bad++;
    end
    chk("press_latency", 32'(cap), 17);
    chk("press_one_pulse", 32'(pulses), 1);
    chk("press_frozen", 32'(bad), 0);
    keys0 = '0;
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk); k++;
      if (!bus0.key_held) got = 1'b1;
    end
    chk("release_window", 32'(k >= 11 && k <= 14), 1);
    chk("release_col", 32'(bus0.col), 32'h3);

    // Bounce of key (1,0): one low sample only
    bus0.enable = 1'b0;
    @(negedge clk);
    keys0 = 9'b1 << 3;
    bus0.enable = 1'b1;
    pulses = 0;
    for (int kk = 1; kk <= 20; kk++) begin
      @(negedge clk);
      if (kk == 5) keys0 = '0;
      if (kk == 9) chk("bounce_col", 32'(bus0.col), 32'h5);
      if (bus0.key_valid) pulses++;
    end
    chk("bounce_no_valid", 32'(pulses), 0);

    // Release glitch of one sample while held
    bus0.enable = 1'b0;
    @(negedge clk);
    keys0 = 9'b1 << 3;
    bus0.enable = 1'b1;
    bad = 0;
    for (int kk = 1; kk <= 50; kk++) begin
      @(negedge clk);
      if (kk == 13) chk("glitch_press_valid", 32'(bus0.key_valid), 1);
      if (kk == 14) keys0 = '0;
      if (kk == 17) keys0 = 9'b1 << 3;
      if (kk >= 14 && bus0.key_held !== 1'b1) bad++;
    end
    chk("glitch_held", 32'(bad), 0);

    // Multi-press in column 1: lowest row wins
    bus0.enable = 1'b0;
    @(negedge clk);
    keys0 = (9'b1 << 1) | (9'b1 << 7);
    bus0.enable = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk); k++;
      if (bus0.key_valid) got = 1'b1;
    end
    chk("multi_latency", 32'(k), 17);
    chk("multi_code", 32'(bus0.key_code), 1);

    // Abort from HELD
    repeat (10) @(negedge clk);
    bus0.enable = 1'b0;
    @(negedge clk);
    chk("abort_col", 32'(bus0.col), 32'h7);
    chk("abort_held", 32'(bus0.key_held), 0);
    chk("abort_code", 32'(bus0.key_code), 1);

    // Reset during DEBOUNCE
    keys0 = 9'b1 << 3;
    bus0.enable = 1'b1;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_col", 32'(bus0.col), 32'h7);
    chk("async_rst_valid", 32'(bus0.key_valid), 0);
    chk("async_rst_code", 32'(bus0.key_code), 0);
    chk("async_rst_held", 32'(bus0.key_held), 0);
    @(negedge clk);
    keys0 = '0;
    bus0.enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.key_valid) pulses++;
    end
    chk("post_rst_no_valid", 32'(pulses), 0);

    // Randomised keypad activity against the model
    bus0.enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r, idx;
      @(negedge clk);
      r = int'($urandom_range(0, 199));
      if (r < 3) keys0 = 9'b1 << $urandom_range(0, 8);
      else if (r < 6) keys0 = '0;
      else if (r == 6) begin idx = int'($urandom_range(0, 8)); keys0[idx] = ~keys0[idx]; end
      else if (r == 7) bus0.enable = ~bus0.enable;
      else if (r < 20 && !bus0.enable) bus0.enable = 1'b1;
    end

    // DEBOUNCE_N = 1 instance
    keys1 = 9'b1;
    bus1.enable = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk); k++;
      if (bus1.key_valid) got = 1'b1;
    end
    chk("n1_latency_c0", 32'(k), 5);
    chk("n1_code_c0", 32'(bus1.key_code), 0);
    repeat (3) @(negedge clk);
    keys1 = '0;
    k = 0; got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk); k++;
      if (!bus1.key_held) got = 1'b1;
    end
    chk("n1_release_col", 32'(bus1.col), 32'h5);
    bus1.enable = 1'b0;
    @(negedge clk);
    keys1 = 9'b1 << 5;
    bus1.enable = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk); k++;
      if (bus1.key_valid) got = 1'b1;
    end
    chk("n1_latency_c2", 32'(k), 13);
    chk("n1_code_c2", 32'(bus1.key_code), 5);

    cmp_on = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
